// File: rtl/lowres_op_sequencer.sv
// Issues the keygen/verify/sign opcode programs to the low-res core, one op per ready_out handshake.
// First op 1 cycle after start when ready_out is high, ops >=3 cycles apart; each op waits on ready_out, and a watchdog guards each completion wait.
module lowres_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       abort,
    output logic [3:0] op_in,
    output logic       op_valid_in,
    input  logic       ready_out,
    output logic       busy_o,
    output logic [1:0] step_o,
    output logic       done_o,
    output logic       error_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [3:0] OP_STOR_SEED = 4'b1111;
    localparam logic [3:0] OP_STOR_PK   = 4'b1100;
    localparam logic [3:0] OP_STOR_SK   = 4'b1101;
    localparam logic [3:0] OP_STOR_SIG  = 4'b1110;
    localparam logic [3:0] OP_LOAD_PK   = 4'b1000;
    localparam logic [3:0] OP_LOAD_SK   = 4'b1001;
    localparam logic [3:0] OP_LOAD_SIG  = 4'b1010;
    localparam logic [3:0] OP_DIGEST    = 4'b0001;
    localparam logic [3:0] OP_SIGN      = 4'b0010;
    localparam logic [3:0] OP_VRFY      = 4'b0100;
    localparam logic [3:0] OP_KGEN      = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BLANK,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t           state;
    logic [1:0]       step;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] wd;

    // Each row is packed step3..step0 so step selects a 4-bit slice.
    function automatic logic [3:0] prog_op(input logic [1:0] m, input logic [1:0] s);
        logic [15:0] row;
        case (m)
            2'd0:    row = {OP_LOAD_PK,  OP_LOAD_SK,  OP_KGEN,   OP_STOR_SEED};
            2'd1:    row = {OP_VRFY,     OP_STOR_SIG, OP_DIGEST, OP_STOR_PK};
            2'd2:    row = {OP_LOAD_SIG, OP_SIGN,     OP_DIGEST, OP_STOR_SK};
            default: row = 16'h0000;
        endcase
        return row[{s, 2'b00} +: 4];
    endfunction

    assign op_valid_in = (state == S_ISSUE) && ready_out && !abort;
    assign op_in       = op_valid_in ? prog_op(mode_q, step) : 4'b0000;
    assign busy_o      = (state != S_IDLE);
    assign step_o      = step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            step    <= 2'd0;
            mode_q  <= 2'd0;
            wd      <= '0;
            done_o  <= 1'b0;
            error_o <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            error_o <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                step  <= 2'd0;
                wd    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (mode != 2'd3) begin
                                mode_q <= mode;
                                step   <= 2'd0;
                                state  <= S_ISSUE;
                            end else begin
                                error_o <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (ready_out) state <= S_BLANK;
                    end
                    // The core still shows the stale ready_out here, so it is not looked at.
                    S_BLANK: begin
                        wd    <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (ready_out) begin
                            if (step == 2'd3) begin
                                done_o <= 1'b1;
                                state  <= S_FINISH;
                            end else begin
                                step  <= step + 2'd1;
                                state <= S_ISSUE;
                            end
                        end else if (TIMEOUT_CYCLES != 0 && wd == WD_LAST) begin
                            error_o <= 1'b1;
                            step    <= 2'd0;
                            state   <= S_IDLE;
                        end else if (TIMEOUT_CYCLES != 0) begin
                            wd <= wd + CNT_W'(1);
                        end
                    end
                    S_FINISH: begin
                        step  <= 2'd0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lowres_op_sequencer.sv
// Scoreboard bench for lowres_op_sequencer: expected ops/done/error events are queued by the
// stimulus and popped by a negedge monitor; a small core model drives ready_out.
module tb_lowres_op_sequencer;

    localparam int K_OP = 0, K_DONE = 1, K_ERR = 2;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [1:0] mode;
    logic [3:0] op_in;
    logic       op_valid_in;
    logic       ready_out = 1'b1;
    logic       busy_o, done_o, error_o;
    logic [1:0] step_o;

    always #5 clk = ~clk;

    lowres_op_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .op_in(op_in), .op_valid_in(op_valid_in), .ready_out(ready_out),
        .busy_o(busy_o), .step_o(step_o), .done_o(done_o), .error_o(error_o)
    );

    typedef struct {
        int         kind;
        logic [3:0] op;
        logic [1:0] step;
    } exp_t;

    exp_t exp_q[$];
    // Hand-written programs, [mode][step].
    logic [3:0] prog_tab [3][4] = '{'{4'hF, 4'h7, 4'h9, 4'h8},
                                    '{4'hC, 4'h1, 4'hE, 4'h4},
                                    '{4'hD, 4'h1, 4'h2, 4'hA}};

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int op_cnt = 0, done_cnt = 0, err_cnt = 0;
    int last_op_cyc = 0, first_op_cyc = 0, done_cyc = 0, err_cyc = 0;
    bit chk_gap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [3:0] op, input logic [1:0] st);
        exp_t e;
        e.kind = kind; e.op = op; e.step = st;
        exp_q.push_back(e);
    endtask

    task automatic push_prog(input int m);
        for (int s = 0; s < 4; s++) push(K_OP, prog_tab[m][s], 2'(s));
        push(K_DONE, 4'h0, 2'd0);
    endtask

    task automatic pop_cmp(input int kind, input logic [3:0] op, input logic [1:0] st);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: kind %0d op 0x%0h step %0d, nothing outstanding", kind, op, st);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        if (kind == K_OP && e.kind == K_OP) begin
            check("op_code", op, e.op);
            check("op_step", st, e.step);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor
    always @(negedge clk) begin
        check("done_err_exclusive", done_o & error_o, 0);
        check("no_op_on_abort", op_valid_in & abort, 0);
        if (!op_valid_in) check("op_zero_without_valid", op_in, 0);
        if (op_valid_in) begin
            if (chk_gap && step_o != 2'd0) check("op_gap", cyc - last_op_cyc, 3);
            if (step_o == 2'd0) first_op_cyc = cyc;
            last_op_cyc = cyc;
            op_cnt++;
            pop_cmp(K_OP, op_in, step_o);
        end
        if (done_o) begin
            done_cnt++; done_cyc = cyc;
            check("busy_during_done", busy_o, 1);
            pop_cmp(K_DONE, 4'h0, 2'd0);
        end
        if (error_o) begin
            err_cnt++; err_cyc = cyc;
            check("idle_during_error", busy_o, 0);
            pop_cmp(K_ERR, 4'h0, 2'd0);
        end
    end

    // Core model: ready_out drops the cycle after an accepted op and stays low for lat cycles.
    bit acc_q = 1'b0, hang = 1'b0;
    int lat = 0, low_cnt = 0, ops_seen = 0, hang_after = 0;
    always @(negedge clk) acc_q = op_valid_in;
    always @(posedge clk) begin
        #1;
        if (acc_q) begin low_cnt = lat; ops_seen++; end
        if (hang && ops_seen >= hang_after) ready_out = 1'b0;
        else if (low_cnt > 0) begin ready_out = 1'b0; low_cnt--; end
        else ready_out = 1'b1;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin tick(); n++; end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: %0d events outstanding after %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (2) tick();
    endtask

    task automatic wait_count(input string name, input bit use_done, input int target, input int budget);
        int n = 0;
        while ((use_done ? done_cnt : op_cnt) < target && n < budget) begin tick(); n++; end
        if ((use_done ? done_cnt : op_cnt) < target) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: count %0d, required %0d within %0d cycles",
                     name, use_done ? done_cnt : op_cnt, target, budget);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_op_in"}, op_in, 0);
        check({tag, "_op_valid"}, op_valid_in, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_step"}, step_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_error"}, error_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, e0, o0, s_cyc;
        rst = 1'b1; start = 1'b0; mode = 2'd0; abort = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Keygen with a 5-cycle busy core
        lat = 5; d0 = done_cnt;
        push_prog(0);
        mode = 2'd0; start = 1'b1; tick(); start = 1'b0;
        wait_drain("keygen_drain", 300);
        check("keygen_done_count", done_cnt - d0, 1);
        check("keygen_done_latency", done_cyc - last_op_cyc, 7);
        check("keygen_busy_after", busy_o, 0);

        // Sign then verify, back to back
        lat = 0; d0 = done_cnt;
        push_prog(2);
        push_prog(1);
        mode = 2'd2; start = 1'b1; tick(); start = 1'b0;
        wait_count("sign_done_wait", 1'b1, d0 + 1, 100);
        mode = 2'd1; start = 1'b1; tick(); start = 1'b0;
        wait_drain("sign_verify_drain", 100);
        check("sign_verify_done_count", done_cnt - d0, 2);

        // Illegal mode
        e0 = err_cnt; o0 = op_cnt;
        push(K_ERR, 4'h0, 2'd0);
        mode = 2'd3; start = 1'b1; tick(); start = 1'b0;
        check("illegal_busy", busy_o, 0);
        wait_drain("illegal_drain", 10);
        check("illegal_err_count", err_cnt - e0, 1);
        check("illegal_no_op", op_cnt - o0, 0);

        // Watchdog: core hangs after the 2nd op
        lat = 0; hang = 1'b1; hang_after = ops_seen + 2;
        d0 = done_cnt; e0 = err_cnt;
        push(K_OP, 4'hF, 2'd0);
        push(K_OP, 4'h7, 2'd1);
        push(K_ERR, 4'h0, 2'd0);
        mode = 2'd0; start = 1'b1; tick(); start = 1'b0;
        wait_drain("timeout_drain", 100);
        check("timeout_latency", err_cyc - last_op_cyc, 18);
        check("timeout_err_count", err_cnt - e0, 1);
        check("timeout_no_done", done_cnt - d0, 0);
        check("timeout_step", step_o, 0);
        hang = 1'b0;
        d0 = done_cnt;
        push_prog(0);
        start = 1'b1; tick(); start = 1'b0;
        wait_drain("after_timeout_drain", 100);
        check("after_timeout_done", done_cnt - d0, 1);

        // Abort in WAIT at step 2, same cycle ready_out rises
        lat = 3; d0 = done_cnt; e0 = err_cnt; o0 = op_cnt;
        for (int s = 0; s < 3; s++) push(K_OP, prog_tab[0][s], 2'(s));
        mode = 2'd0; start = 1'b1; tick(); start = 1'b0;
        wait_count("abort_op_wait", 1'b0, o0 + 3, 100);
        repeat (3) tick();
        abort = 1'b1;
        @(negedge clk);
        check("abort_setup_ready", ready_out, 1);
        check("abort_setup_step", step_o, 2);
        check("abort_setup_busy", busy_o, 1);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy_next", busy_o, 0);
        check("abort_step_next", step_o, 0);
        repeat (10) tick();
        check("abort_no_more_ops", op_cnt - o0, 3);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_error", err_cnt - e0, 0);
        check("abort_queue_empty", exp_q.size(), 0);

        // Reset mid-program
        lat = 5; d0 = done_cnt; o0 = op_cnt;
        push(K_OP, 4'hF, 2'd0);
        push(K_OP, 4'h7, 2'd1);
        start = 1'b1; tick(); start = 1'b0;
        wait_count("rst_op_wait", 1'b0, o0 + 2, 100);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_all_zero("midrst");
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("midrst_no_more_ops", op_cnt - o0, 2);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_queue_empty", exp_q.size(), 0);

        // start held high, ready_out permanently high
        lat = 0;
        repeat (3) tick();
        chk_gap = 1'b1; d0 = done_cnt; o0 = op_cnt;
        push_prog(0);
        mode = 2'd0; start = 1'b1; s_cyc = cyc;
        tick();
        wait_count("held_op_wait", 1'b0, o0 + 4, 100);
        start = 1'b0;
        wait_drain("held_drain", 100);
        chk_gap = 1'b0;
        check("held_first_op_latency", first_op_cyc - s_cyc, 1);
        check("held_op_count", op_cnt - o0, 4);
        check("held_done_count", done_cnt - d0, 1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lowres_op_sequencer.md
Name: lowres_op_sequencer

Overview:
- Command sequencer for the low-resource Dilithium core's 4-bit opcode port.
- Accepts a top-level start/mode request and issues the full opcode program for keygen, sign or verify, one op at a time.
- Gates each op on the core's ready_out and guards every wait with a watchdog.
- Sits between the high-performance top interface and the low-res core. Data words are not handled here; only command sequencing, completion and error reporting.

Parameters:
- TIMEOUT_CYCLES, 1048576, max cycles to wait for ready_out after an op; 0 disables the watchdog.
- CNT_W, $clog2(TIMEOUT_CYCLES+1) (min 1), watchdog counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse/level, sampled only in IDLE
- mode  in  2  0=keygen, 1=verify, 2=sign, 3=illegal
- abort  in  1  cancel current program
- op_in  out  4  opcode to core
- op_valid_in  out  1  opcode valid, single-cycle per op
- ready_out  in  1  core idle/op-complete level
- busy_o  out  1  program in progress
- step_o  out  2  index of op currently issued/awaited
- done_o  out  1  one-cycle pulse, program completed
- error_o  out  1  one-cycle pulse, illegal mode or timeout

Behaviour:
- Opcode encodings:
  - STOR = {2'b11, payload}; LOAD = {2'b10, payload}.
  - Payload: PK=00, SK=01, SIG=10, SEED=11.
  - DIGEST_MSG=0001, SIGN=0010, VRFY=0100, KGEN=0111.
- Programs, 4 ops each, step 0..3:
  - keygen: 1111, 0111, 1001, 1000
  - verify: 1100, 0001, 1110, 0100
  - sign: 1101, 0001, 0010, 1010
- Reset: state=IDLE, step=0, mode_q=0, watchdog=0. All outputs 0 (op_in=0, op_valid_in=0, busy_o=0, step_o=0, done_o=0, error_o=0).
- States: IDLE, ISSUE, BLANK, WAIT, FINISH.
- IDLE:
  - start=1 with mode<3: latch mode_q, step=0, go ISSUE.
  - start=1 with mode=3: error_o pulse next cycle, stay IDLE.
- ISSUE:
  - op_in = program[mode_q][step].
  - op_valid_in = ready_out (combinational, Mealy). op_in is 0 whenever op_valid_in=0.
  - On ready_out=1: go BLANK.
- BLANK: exactly one cycle. ready_out is ignored, since the core drops ready_out the cycle after accepting an op. Clear watchdog, go WAIT.
- WAIT:
  - Watchdog increments each cycle while ready_out=0.
  - On ready_out=1: if step<3, step+1 and go ISSUE; if step=3, go FINISH.
  - Watchdog reaching TIMEOUT_CYCLES (when non-zero): error_o pulse, go IDLE, step=0.
- FINISH: done_o=1 for one cycle, go IDLE.
- Latency from start to first op_valid_in: 1 cycle if ready_out is already high. Consecutive ops are at least 3 cycles apart (ISSUE, BLANK, WAIT with ready_out high).
- busy_o = 1 in ISSUE/BLANK/WAIT/FINISH, else 0. step_o = step.
- start while busy: ignored; no queueing.
- abort=1 in any non-IDLE state:
  - Return to IDLE next cycle; no done_o, no error_o.
  - abort has priority over done, timeout and op issue in the same cycle. No op_valid_in is driven in a cycle where abort=1.
- ISSUE has no watchdog: a core that never asserts ready_out there is cancelled only by abort or rst.
- rst mid-program: immediate return to reset values next edge; no pulse emitted.
- done_o and error_o are mutually exclusive and never high in the same cycle.

Test Plan:
- Keygen, mode=0, ready_out modelled as low 5 cycles after each op → op_valid_in pulses with op_in 1111, 0111, 1001, 1000 in order; done_o one cycle after the 4th completion; busy_o low afterwards.
- Sign (mode=2) and verify (mode=1), back-to-back starts → sign issues 1101, 0001, 0010, 1010 and verify issues 1100, 0001, 1110, 0100; exactly one done_o each; step_o tracks 0..3.
- mode=3 with start=1 → error_o single pulse, no op_valid_in, busy_o stays 0.
- TIMEOUT_CYCLES=16, ready_out held low after the 2nd op → error_o exactly 16 WAIT cycles later, state IDLE, no done_o; next start runs normally from step 0.
- abort asserted in WAIT at step 2 of keygen, simultaneously with ready_out rising → no further op_valid_in, no done_o/error_o, busy_o=0 next cycle. Separately, rst mid-program → all outputs 0 next cycle.
- start held high during a program and ready_out held permanently high → start ignored while busy; ops spaced exactly 3 cycles apart; the BLANK cycle never issues an op.
